vector_alu_seq: RTL and testbench
=================================

Name: vector_alu_seq

Overview:
Handshaked, sequenced vector ALU for the vector datapath. It applies one 3-bit opcode to all LANES lanes in parallel, including MUL/DIV/MOD/SHL, and reports per-lane flags. Single-cycle ops take one cycle. DIV/MOD run an iterative per-lane divider. Sits between the vector register-file read stage and writeback, with valid/ready on both sides.

Parameters:
WIDTH, 24, bits per lane element
LANES, 8, number of vector lanes (≥1)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  operation request
in_ready  out  1  block can accept a request this cycle
sel  in  3  opcode: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 MOD, 101 SHL, 110 PASSA, 111 PASSB
a  in  LANES×WIDTH  operand A, packed [LANES-1:0][WIDTH-1:0]
b  in  LANES×WIDTH  operand B, same packing
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  LANES×WIDTH  per-lane result
flag_n, flag_z, flag_v, flag_c  out  LANES each  per-lane Negative/Zero/oVerflow/Carry
all_zero  out  1  AND of flag_z

Behaviour:
- Clock is clk. Reset is synchronous, active-low (rst_n). While rst_n=0 at a rising edge: state←IDLE, out_valid←0, result←0, all flags←0. in_ready=0 whenever rst_n=0.
- A reset mid-operation abandons the operation. No result is emitted.
- FSM states: IDLE, DIV_RUN, DONE.
  - IDLE: in_ready=1. Accept on in_valid. sel≠011/100 → compute, register, go to DONE (latency 1). sel=011/100 → latch operands, count←0, go to DIV_RUN.
  - DIV_RUN: one restoring-division step per lane per cycle. After WIDTH steps go to DONE. DIV/MOD latency is therefore WIDTH+1 from acceptance.
  - DONE: out_valid=1. result and flags are held stable until out_ready. in_ready=out_ready. A handshake in the same cycle as out_ready is accepted and processed as if from IDLE (back-to-back). out_ready with no new request → IDLE.
- Arithmetic per lane (unsigned storage, WIDTH bits, results truncated):
  - ADD: C=carry-out. V=signed overflow.
  - SUB: a−b. C=1 iff a≥b (no borrow). V=signed overflow.
  - MUL: low WIDTH bits of a×b. V=C=1 iff high WIDTH bits are nonzero.
  - DIV: quotient. MOD: remainder. Divide by zero: quotient all-ones, remainder=a, V=1, C=0.
  - SHL: shift amount s=b lane value. s≥WIDTH → result 0. C=last bit shifted out (a[WIDTH-s] for 1≤s≤WIDTH, else 0). V=0.
  - PASSA/PASSB: result=a/b, V=C=0.
- N=result MSB and Z=(result==0) for every op.
- in_valid while not in_ready is ignored; the requester holds it.

Optional Feature:
Macro VECTOR_ALU_LANE_MASK_EN.
- Defined: adds input lane_mask [LANES], sampled at acceptance. A masked-off lane (bit=0) outputs result=a and all its flags 0. For DIV/MOD, the masked lane's divider stays idle. all_zero considers only enabled lanes, and is 1 if none are enabled.
- Undefined: port absent; all lanes are always active.

Decomposition:
- Package vector_alu_pkg: op enum (OP_ADD..OP_PASSB), typedef lane_flags_t {n,z,v,c}, FSM state enum.
- Sub-module vector_alu_lane_div: one iterative restoring divider (start, a, b → quot, rem, dbz), instantiated LANES times via generate.
- Single-cycle ops are inline, with a generate loop per lane.

Test Plan:
- ADD, lane0 a=0x7FFFFF b=0x000001, other lanes a=b=0 → after 1 cycle: out_valid, lane0=0x800000 N=1 V=1 C=0; other lanes Z=1; all_zero=0.
- SUB a=5 b=7 → 0xFFFFFE, C=0, N=1. MUL a=b=0x001000 → 0x000000, Z=1, V=C=1.
- DIV a=100 b=7 → out_valid exactly 25 cycles after acceptance, quot 14. MOD on the same operands → 2. DIV b=0 → 0xFFFFFF, V=1. MOD b=0 → 100.
- SHL a=0x800001 b=1 → 0x000002, C=1. b=30 → 0, C=0, Z=1.
- Backpressure: out_ready=0 for 5 cycles in DONE → result stable, in_ready=0. Then out_ready=1 with in_valid=1 (PASSB) → next result 1 cycle later.
- rst_n=0 at cycle 10 of DIV_RUN → next cycle out_valid=0, in_ready=0 while reset held. Release reset → ADD accepted, correct result, no stale DIV output.

Source files
------------

// File: rtl/vector_alu_pkg.sv
// vector_alu_pkg: shared types for the sequenced vector ALU.
//   op_e         - 3-bit opcode (ADD, SUB, MUL, DIV, MOD, SHL, PASSA, PASSB)
//   lane_flags_t - per-lane {n, z, v, c} flag bundle
//   state_e      - control FSM states (IDLE, DIV_RUN, DONE)
//   is_div_op    - true for the opcodes that go through the iterative divider
package vector_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_MUL   = 3'b010,
    OP_DIV   = 3'b011,
    OP_MOD   = 3'b100,
    OP_SHL   = 3'b101,
    OP_PASSA = 3'b110,
    OP_PASSB = 3'b111
  } op_e;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } lane_flags_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DIV_RUN = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  function automatic logic is_div_op(input op_e op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/vector_alu_lane_div.sv
// vector_alu_lane_div: one lane of the iterative restoring divider.
// Ports:
//   clk, rst_n - clock, synchronous active-low reset
//   start      - latch a (dividend) and b (divisor), clear partial remainder
//   step       - perform one restoring step this cycle
//   a, b       - operands, sampled on start
//   quot, rem  - quotient/remainder as they will be after the step in
//                progress; after WIDTH steps these are the final values
//   dbz        - latched divisor is zero
// A zero divisor needs no special casing: every trial subtract succeeds, so
// the quotient fills with ones and the dividend shifts into the remainder.
module vector_alu_lane_div #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             dbz
);

  logic [WIDTH-1:0] q_q, r_q, d_q;
  logic [WIDTH:0]   shifted;
  logic             ge;

  always_comb begin
    // bring the next dividend bit into the partial remainder
    shifted = {r_q, q_q[WIDTH-1]};
    ge      = (shifted >= {1'b0, d_q});
    quot    = (q_q << 1) | WIDTH'(ge);
    // when ge, the difference is below the divisor and fits in WIDTH bits
    rem     = ge ? (shifted[WIDTH-1:0] - d_q) : shifted[WIDTH-1:0];
  end

  assign dbz = (d_q == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= '0;
      r_q <= '0;
      d_q <= '0;
    end else if (start) begin
      q_q <= a;
      r_q <= '0;
      d_q <= b;
    end else if (step) begin
      q_q <= quot;
      r_q <= rem;
    end
  end

endmodule

// File: rtl/vector_alu_seq.sv
// vector_alu_seq: handshaked vector ALU, one opcode applied to all lanes.
// Single-cycle ops register their result on acceptance; DIV/MOD run WIDTH
// restoring steps per lane before the result is registered.
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   in_valid / in_ready   - request handshake (sel, a, b)
//   sel                   - opcode (see vector_alu_pkg::op_e)
//   a, b                  - packed [LANES-1:0][WIDTH-1:0] operands
//   out_valid / out_ready - result handshake
//   result                - per-lane result, held until consumed
//   flag_n/z/v/c          - per-lane Negative/Zero/oVerflow/Carry
//   all_zero              - AND of flag_z over enabled lanes
// Optional: define VECTOR_ALU_LANE_MASK_EN to add lane_mask[LANES-1:0],
// sampled at acceptance; masked lanes pass a through with all flags clear.
module vector_alu_seq
  import vector_alu_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int LANES = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [2:0]                   sel,
  input  logic [LANES-1:0][WIDTH-1:0]  a,
  input  logic [LANES-1:0][WIDTH-1:0]  b,
`ifdef VECTOR_ALU_LANE_MASK_EN
  input  logic [LANES-1:0]             lane_mask,
`endif
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES-1:0][WIDTH-1:0]  result,
  output logic [LANES-1:0]             flag_n,
  output logic [LANES-1:0]             flag_z,
  output logic [LANES-1:0]             flag_v,
  output logic [LANES-1:0]             flag_c,
  output logic                         all_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e                        state_q, state_d;
  logic [CW-1:0]                 cnt_q;
  logic                          is_mod_q;
  logic [LANES-1:0][WIDTH-1:0]   res_q;
  lane_flags_t [LANES-1:0]       flg_q;

  op_e                           op_in;
  logic                          is_div;
  logic                          accept;
  logic                          last_step;

  logic [LANES-1:0][WIDTH-1:0]   alu_res, div_res;
  lane_flags_t [LANES-1:0]       alu_flg, div_flg;

  // act_in: lanes enabled for the request being offered
  // act_q : lanes enabled for the operation in flight / on display
  logic [LANES-1:0]              act_in, act_q;

`ifdef VECTOR_ALU_LANE_MASK_EN
  logic [LANES-1:0]              mask_q;
  logic [LANES-1:0][WIDTH-1:0]   a_q;     // pass-through value for masked DIV lanes
  assign act_in = lane_mask;
  assign act_q  = mask_q;
`else
  assign act_in = '1;
  assign act_q  = '1;
`endif

  assign op_in     = op_e'(sel);
  assign is_div    = is_div_op(op_in);
  assign accept    = in_valid && in_ready;
  assign last_step = (state_q == ST_DIV_RUN) && (cnt_q == CW'(WIDTH - 1));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = rst_n;
        if (in_valid && rst_n) state_d = is_div ? ST_DIV_RUN : ST_DONE;
      end
      ST_DIV_RUN: begin
        if (last_step) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        // consuming the result frees the block in the same cycle
        in_ready  = rst_n && out_ready;
        if (in_valid && in_ready) state_d = is_div ? ST_DIV_RUN : ST_DONE;
        else if (out_ready)       state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- lanes
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [WIDTH:0]     sum, shl;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   r;
    logic               v, c;
    logic [WIDTH-1:0]   dq, dr, dsel;
    logic               dbz;

    always_comb begin
      sum  = {1'b0, a[gi]} + {1'b0, b[gi]};
      prod = {{WIDTH{1'b0}}, a[gi]} * {{WIDTH{1'b0}}, b[gi]};
      // bit WIDTH of the widened shift is the last bit shifted out; it and
      // the low bits both fall to zero once the amount exceeds WIDTH
      shl  = {1'b0, a[gi]} << b[gi];
      r    = '0;
      v    = 1'b0;
      c    = 1'b0;
      unique case (op_in)
        OP_ADD: begin
          r = sum[WIDTH-1:0];
          c = sum[WIDTH];
          v = (a[gi][WIDTH-1] == b[gi][WIDTH-1]) && (r[WIDTH-1] != a[gi][WIDTH-1]);
        end
        OP_SUB: begin
          r = a[gi] - b[gi];
          c = (a[gi] >= b[gi]);
          v = (a[gi][WIDTH-1] != b[gi][WIDTH-1]) && (r[WIDTH-1] != a[gi][WIDTH-1]);
        end
        OP_MUL: begin
          r = prod[WIDTH-1:0];
          v = |prod[2*WIDTH-1:WIDTH];
          c = v;
        end
        OP_SHL: begin
          r = shl[WIDTH-1:0];
          c = shl[WIDTH];
        end
        OP_PASSA: r = a[gi];
        OP_PASSB: r = b[gi];
        default: ;  // DIV/MOD take the divider path
      endcase
    end

    assign alu_res[gi] = act_in[gi] ? r : a[gi];
    assign alu_flg[gi] = act_in[gi] ?
                         lane_flags_t'({r[WIDTH-1], (r == '0), v, c}) : '0;

    vector_alu_lane_div #(.WIDTH(WIDTH)) u_div (
      .clk   (clk),
      .rst_n (rst_n),
      .start (accept && is_div && act_in[gi]),
      .step  ((state_q == ST_DIV_RUN) && act_q[gi]),
      .a     (a[gi]),
      .b     (b[gi]),
      .quot  (dq),
      .rem   (dr),
      .dbz   (dbz)
    );

    assign dsel = is_mod_q ? dr : dq;

`ifdef VECTOR_ALU_LANE_MASK_EN
    assign div_res[gi] = act_q[gi] ? dsel : a_q[gi];
    assign div_flg[gi] = act_q[gi] ?
                         lane_flags_t'({dsel[WIDTH-1], (dsel == '0), dbz, 1'b0}) : '0;
`else
    assign div_res[gi] = dsel;
    assign div_flg[gi] = lane_flags_t'({dsel[WIDTH-1], (dsel == '0), dbz, 1'b0});
`endif

    assign flag_n[gi] = flg_q[gi].n;
    assign flag_z[gi] = flg_q[gi].z;
    assign flag_v[gi] = flg_q[gi].v;
    assign flag_c[gi] = flg_q[gi].c;
  end

  // ---------------------------------------------------------------- datapath regs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      is_mod_q <= 1'b0;
      res_q    <= '0;
      flg_q    <= '0;
`ifdef VECTOR_ALU_LANE_MASK_EN
      mask_q   <= '1;   // keeps all_zero tied to flag_z after reset
      a_q      <= '0;
`endif
    end else if (accept) begin
      cnt_q    <= '0;
      is_mod_q <= (op_in == OP_MOD);
`ifdef VECTOR_ALU_LANE_MASK_EN
      mask_q   <= lane_mask;
      a_q      <= a;
`endif
      if (!is_div) begin
        res_q <= alu_res;
        flg_q <= alu_flg;
      end
    end else if (state_q == ST_DIV_RUN) begin
      cnt_q <= cnt_q + CW'(1);
      if (last_step) begin
        res_q <= div_res;
        flg_q <= div_flg;
      end
    end
  end

  assign result   = res_q;
  // disabled lanes count as zero so they never hold all_zero low
  assign all_zero = &(flag_z | ~act_q);

endmodule

// File: tb/tb_vector_alu_seq.sv
// tb_vector_alu_seq: directed bench for vector_alu_seq. A cycle-level
// behavioural model (plain arithmetic per lane, a countdown for the divider
// latency) is advanced on every falling edge and compared against the DUT;
// directed sections add hand-computed literal expectations.
module tb_vector_alu_seq;

  localparam int WIDTH = 24;
  localparam int LANES = 8;

  typedef logic [LANES-1:0][WIDTH-1:0] vec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       sel;
  vec_t             a, b;
  logic             out_valid;
  logic             out_ready;
  vec_t             result;
  logic [LANES-1:0] flag_n, flag_z, flag_v, flag_c;
  logic             all_zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vector_alu_seq #(.WIDTH(WIDTH), .LANES(LANES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .a         (a),
    .b         (b),
`ifdef VECTOR_ALU_LANE_MASK_EN
    .lane_mask ({LANES{1'b1}}),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_n    (flag_n),
    .flag_z    (flag_z),
    .flag_v    (flag_v),
    .flag_c    (flag_c),
    .all_zero  (all_zero)
  );

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // ------------------------------------------------------------ model
  task automatic lane_model(input int op, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                            output logic [WIDTH-1:0] r, output logic n, output logic z,
                            output logic v, output logic c);
    longint lim = longint'(1) << WIDTH;
    longint ux = longint'(x);
    longint uy = longint'(y);
    longint sx = x[WIDTH-1] ? ux - lim : ux;
    longint sy = y[WIDTH-1] ? uy - lim : uy;
    longint t, ss;
    r = '0; v = 1'b0; c = 1'b0;
    case (op)
      0: begin t = ux + uy; r = t[WIDTH-1:0]; c = (t >= lim);
               ss = sx + sy; v = (ss >= lim/2) || (ss < -(lim/2)); end
      1: begin t = ux - uy; r = t[WIDTH-1:0]; c = (ux >= uy);
               ss = sx - sy; v = (ss >= lim/2) || (ss < -(lim/2)); end
      2: begin t = ux * uy; r = t[WIDTH-1:0]; v = ((t >> WIDTH) != 0); c = v; end
      3: begin if (uy == 0) begin r = '1; v = 1'b1; end
               else begin t = ux / uy; r = t[WIDTH-1:0]; end end
      4: begin if (uy == 0) begin r = x; v = 1'b1; end
               else begin t = ux % uy; r = t[WIDTH-1:0]; end end
      5: begin if (uy == 0) r = x;
               else if (uy <= WIDTH) begin t = (ux << uy); r = t[WIDTH-1:0]; c = x[WIDTH - int'(uy)]; end
               else r = '0; end
      6: r = x;
      default: r = y;
    endcase
    n = r[WIDTH-1];
    z = (r == '0);
  endtask

  vec_t             m_res = '0, p_res = '0;
  logic [LANES-1:0] m_n = '0, m_z = '0, m_v = '0, m_c = '0;
  logic [LANES-1:0] p_n = '0, p_z = '0, p_v = '0, p_c = '0;
  logic             m_valid = 1'b0;
  int               m_wait = 0;

  // inputs only change just after a rising edge, so at the falling edge they
  // are exactly what the next rising edge will sample
  always @(negedge clk) begin
    logic mrdy, acc;
    mrdy = rst_n && (m_wait == 0) && (!m_valid || out_ready);
    chk("in_ready", in_ready, mrdy);
    chk("out_valid", out_valid, m_valid);
    if (m_valid) begin
      chk("result", result, m_res);
      chk("flag_n", flag_n, m_n);
      chk("flag_z", flag_z, m_z);
      chk("flag_v", flag_v, m_v);
      chk("flag_c", flag_c, m_c);
      chk("all_zero", all_zero, &m_z);
    end
    if (!rst_n) begin
      m_valid = 1'b0; m_wait = 0;
    end else begin
      acc = in_valid && mrdy;
      if (m_valid && out_ready) m_valid = 1'b0;
      if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) begin
          m_valid = 1'b1;
          m_res = p_res; m_n = p_n; m_z = p_z; m_v = p_v; m_c = p_c;
        end
      end
      if (acc) begin
        for (int l = 0; l < LANES; l++)
          lane_model(int'(sel), a[l], b[l], p_res[l], p_n[l], p_z[l], p_v[l], p_c[l]);
        if (sel == 3'd3 || sel == 3'd4) m_wait = WIDTH;
        else begin
          m_valid = 1'b1;
          m_res = p_res; m_n = p_n; m_z = p_z; m_v = p_v; m_c = p_c;
        end
      end
    end
  end

  // ------------------------------------------------------------ stimulus helpers
  task automatic send(input logic [2:0] op, input vec_t av, input vec_t bv);
    @(posedge clk); #1;
    in_valid = 1'b1; sel = op; a = av; b = bv;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    chk("send_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // cycles from the acceptance cycle to the first cycle with out_valid
  task automatic wait_out(output int lat);
    lat = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
  endtask

  function automatic vec_t fill(input logic [WIDTH-1:0] v);
    vec_t t;
    for (int l = 0; l < LANES; l++) t[l] = v;
    return t;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t va, vb;
    int   lat;
    rst_n = 1'b0; in_valid = 1'b0; sel = '0; a = '0; b = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_result", result, '0);
    chk("rst_flags", {flag_n, flag_z, flag_v, flag_c}, '0);
    chk("rst_all_zero", all_zero, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;

    // ADD signed overflow on lane 0, zeros elsewhere
    va = '0; vb = '0; va[0] = 24'h7FFFFF; vb[0] = 24'h000001;
    send(3'd0, va, vb); wait_out(lat);
    chk("add_lat", lat, 1);
    chk("add_res0", result[0], 24'h800000);
    chk("add_nvc0", {flag_n[0], flag_v[0], flag_c[0]}, 3'b110);
    chk("add_z", flag_z, 8'hFE);
    chk("add_all_zero", all_zero, 1'b0);

    send(3'd1, fill(24'd5), fill(24'd7)); wait_out(lat);
    chk("sub_res0", result[0], 24'hFFFFFE);
    chk("sub_nc0", {flag_n[0], flag_c[0]}, 2'b10);

    send(3'd2, fill(24'h001000), fill(24'h001000)); wait_out(lat);
    chk("mul_res0", result[0], 24'h0);
    chk("mul_zvc0", {flag_z[0], flag_v[0], flag_c[0]}, 3'b111);
    chk("mul_all_zero", all_zero, 1'b1);

    // DIV/MOD with a zero divisor on lane 1
    va = fill(24'd100); vb = fill(24'd7); vb[1] = '0; vb[2] = 24'd1; va[2] = 24'hFFFFFF;
    send(3'd3, va, vb); wait_out(lat);
    chk("div_lat", lat, 25);
    chk("div_quot0", result[0], 24'd14);
    chk("div_dbz1", result[1], 24'hFFFFFF);
    chk("div_v", flag_v[1:0], 2'b10);
    send(3'd4, va, vb); wait_out(lat);
    chk("mod_lat", lat, 25);
    chk("mod_rem0", result[0], 24'd2);
    chk("mod_dbz1", result[1], 24'd100);

    // SHL boundaries: 1, 30, WIDTH, WIDTH-1
    va = fill(24'h800001); vb = '0;
    vb[0] = 24'd1; vb[1] = 24'd30; va[2] = 24'd1; vb[2] = 24'd24; va[3] = 24'd1; vb[3] = 24'd23;
    send(3'd5, va, vb); wait_out(lat);
    chk("shl_res0", result[0], 24'h000002);
    chk("shl_c0", flag_c[0], 1'b1);
    chk("shl_res1", result[1], 24'h0);
    chk("shl_zc1", {flag_z[1], flag_c[1]}, 2'b10);
    chk("shl_c2", {flag_z[2], flag_c[2]}, 2'b11);
    chk("shl_res3", result[3], 24'h800000);

    // carry-out and negative-minus-positive overflow
    va = fill(24'hFFFFFF); vb = fill(24'h000001);
    send(3'd0, va, vb); wait_out(lat);
    chk("add_carry", {flag_z[0], flag_c[0], flag_v[0]}, 3'b110);
    va = fill(24'h800000);
    send(3'd1, va, vb); wait_out(lat);
    chk("sub_ovf_res", result[0], 24'h7FFFFF);
    chk("sub_ovf_vc", {flag_v[0], flag_c[0]}, 2'b11);

    // backpressure, then back-to-back accept while consuming
    @(posedge clk); #1 out_ready = 1'b0;
    send(3'd6, fill(24'h123456), fill(24'h0));
    wait_out(lat);
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold", result[0], 24'h123456);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_valid", out_valid, 1'b1);
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; sel = 3'd7; a = '0; b = fill(24'hABCDEF);
    @(negedge clk);
    chk("b2b_in_ready", in_ready, 1'b1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_valid", out_valid, 1'b1);
    chk("b2b_res", result[0], 24'hABCDEF);

    // reset during DIV_RUN abandons the division
    send(3'd3, fill(24'd100), fill(24'd7));
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mid_rst_valid", out_valid, 1'b0);
      chk("mid_rst_ready", in_ready, 1'b0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    va = fill(24'd3); vb = fill(24'd4);
    send(3'd0, va, vb); wait_out(lat);
    chk("post_rst_lat", lat, 1);
    chk("post_rst_res", result[7], 24'd7);
    repeat (30) @(negedge clk);
    chk("no_stale_div", out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
